// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Per-thread ALU. Single-cycle ADD/SUB/MUL/CMP, iterative DIV.
// Revision : 1.0
// ============================================================================
module alu_multicycle #(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [1:0]            decoded_alu_arithmetic_mux,
  input  logic                  decoded_alu_output_mux,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] alu_out_hi,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int              c_DW       = DATA_WIDTH;
  localparam int              c_CW       = $clog2(DATA_WIDTH);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DATA_WIDTH - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [1:0]      c_OP_ADD   = 2'b00;
  localparam logic [1:0]      c_OP_SUB   = 2'b01;
  localparam logic [1:0]      c_OP_MUL   = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [c_DW-1:0]   r_quot, w_quot_nxt;
  logic [c_DW-1:0]   r_rem, w_rem_nxt;
  logic [c_DW-1:0]   r_divisor, w_divisor_nxt;
  logic [c_DW-1:0]   r_alu_out, w_alu_out_nxt;
  logic [c_DW-1:0]   r_alu_out_hi, w_alu_out_hi_nxt;
  logic              r_done, w_done_nxt;
  logic              r_div_by_zero, w_div_by_zero_nxt;

  logic [c_DW:0]     w_sum, w_diff;
  logic [2*c_DW-1:0] w_prod;
  logic              w_lt, w_gt, w_eq;
  logic [c_DW:0]     w_rem_shift, w_rem_sub;
  logic              w_fits;
  logic [c_DW-1:0]   w_quot_step, w_rem_step;

  assign w_sum  = {1'b0, rs} + {1'b0, rt};
  assign w_diff = {1'b0, rs} - {1'b0, rt};
  assign w_prod = {{c_DW{1'b0}}, rs} * {{c_DW{1'b0}}, rt};
  assign w_eq   = (rs == rt);

  generate
    if (SIGNED_CMP) begin : g_cmp_signed
      assign w_lt = ($signed(rs) < $signed(rt));
      assign w_gt = ($signed(rs) > $signed(rt));
    end else begin : g_cmp_unsigned
      assign w_lt = (rs < rt);
      assign w_gt = (rs > rt);
    end
  endgenerate

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_rem_shift = {r_rem, r_quot[c_DW-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
  assign w_fits      = ~w_rem_sub[c_DW];
  assign w_quot_step = {r_quot[c_DW-2:0], w_fits};
  assign w_rem_step  = w_fits ? w_rem_sub[c_DW-1:0] : w_rem_shift[c_DW-1:0];

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_quot_nxt        = r_quot;
    w_rem_nxt         = r_rem;
    w_divisor_nxt     = r_divisor;
    w_alu_out_nxt     = r_alu_out;
    w_alu_out_hi_nxt  = r_alu_out_hi;
    w_done_nxt        = 1'b0;
    w_div_by_zero_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && start) begin
          if (decoded_alu_output_mux) begin
            w_alu_out_nxt    = {{(c_DW-3){1'b0}}, w_gt, w_eq, w_lt};
            w_alu_out_hi_nxt = '0;
            w_done_nxt       = 1'b1;
          end else begin
            case (decoded_alu_arithmetic_mux)
              c_OP_ADD: begin
                w_alu_out_nxt    = w_sum[c_DW-1:0];
                w_alu_out_hi_nxt = {{(c_DW-1){1'b0}}, w_sum[c_DW]};
                w_done_nxt       = 1'b1;
              end
              c_OP_SUB: begin
                w_alu_out_nxt    = w_diff[c_DW-1:0];
                w_alu_out_hi_nxt = {{(c_DW-1){1'b0}}, w_diff[c_DW]};
                w_done_nxt       = 1'b1;
              end
              c_OP_MUL: begin
                w_alu_out_nxt    = w_prod[c_DW-1:0];
                w_alu_out_hi_nxt = w_prod[2*c_DW-1:c_DW];
                w_done_nxt       = 1'b1;
              end
              default: begin
                if (rt == '0) begin
                  w_alu_out_nxt     = '1;
                  w_alu_out_hi_nxt  = rs;
                  w_done_nxt        = 1'b1;
                  w_div_by_zero_nxt = 1'b1;
                end else begin
                  w_state_nxt   = S_DIV;
                  w_cnt_nxt     = '0;
                  w_quot_nxt    = rs;
                  w_rem_nxt     = '0;
                  w_divisor_nxt = rt;
                end
              end
            endcase
          end
        end
      end
      S_DIV: begin
        w_quot_nxt = w_quot_step;
        w_rem_nxt  = w_rem_step;
        w_cnt_nxt  = r_cnt + c_CNT_ONE;
        if (r_cnt == c_CNT_LAST) begin
          w_alu_out_nxt    = w_quot_step;
          w_alu_out_hi_nxt = w_rem_step;
          w_done_nxt       = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_quot        <= '0;
      r_rem         <= '0;
      r_divisor     <= '0;
      r_alu_out     <= '0;
      r_alu_out_hi  <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_quot        <= w_quot_nxt;
      r_rem         <= w_rem_nxt;
      r_divisor     <= w_divisor_nxt;
      r_alu_out     <= w_alu_out_nxt;
      r_alu_out_hi  <= w_alu_out_hi_nxt;
      r_done        <= w_done_nxt;
      r_div_by_zero <= w_div_by_zero_nxt;
    end
  end

  assign alu_out     = r_alu_out;
  assign alu_out_hi  = r_alu_out_hi;
  assign busy        = (r_state == S_DIV);
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Self-checking bench for alu_multicycle (unsigned and signed CMP).
// Revision : 1.0
// ============================================================================
module tb_alu_multicycle;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       cmp = 1'b0;
  logic [7:0] rs = 8'd0;
  logic [7:0] rt = 8'd0;

  logic [7:0] out_u, hi_u, out_s, hi_s;
  logic       busy_u, done_u, dbz_u, busy_s, done_s, dbz_s;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] last_u = 8'd0;
  logic [7:0] last_hi = 8'd0;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_WIDTH(8), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .decoded_alu_arithmetic_mux(op), .decoded_alu_output_mux(cmp),
    .rs(rs), .rt(rt), .alu_out(out_u), .alu_out_hi(hi_u),
    .busy(busy_u), .done(done_u), .div_by_zero(dbz_u));

  alu_multicycle #(.DATA_WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .decoded_alu_arithmetic_mux(op), .decoded_alu_output_mux(cmp),
    .rs(rs), .rt(rt), .alu_out(out_s), .alu_out_hi(hi_s),
    .busy(busy_s), .done(done_s), .div_by_zero(dbz_s));

  typedef struct {
    string      name;
    logic [1:0] op;
    logic       cmp;
    logic [7:0] a, b;
    logic [7:0] eu, es, eh;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference computed with integer arithmetic straight from the operation rules.
  task automatic model(input logic [1:0] mop, input logic mcmp, input logic [7:0] a, b,
                       output logic [7:0] eu, es, eh, output logic edbz, output int elat);
    int ia, ib, sa, sb, r;
    ia = int'(a); ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    edbz = 1'b0; elat = 0; eh = 8'd0; eu = 8'd0;
    if (mcmp) begin
      eu = (ia > ib) ? 8'd4 : (ia == ib) ? 8'd2 : 8'd1;
      es = (sa > sb) ? 8'd4 : (sa == sb) ? 8'd2 : 8'd1;
    end else begin
      case (mop)
        2'd0: begin r = ia + ib; eu = 8'(r % 256); eh = 8'(r / 256); end
        2'd1: begin r = ia - ib + 256; eu = 8'(r % 256); eh = (ia < ib) ? 8'd1 : 8'd0; end
        2'd2: begin r = ia * ib; eu = 8'(r % 256); eh = 8'(r / 256); end
        default: begin
          if (ib == 0) begin eu = 8'hFF; eh = a; edbz = 1'b1; end
          else begin eu = 8'(ia / ib); eh = 8'(ia % ib); elat = 8; end
        end
      endcase
      es = eu;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] mop, input logic mcmp,
                        input logic [7:0] a, b, eu, es, eh, input logic edbz,
                        input int elat, input bit mid_start, input bit drop_en);
    int lat, busy_cnt, hold_bad;
    enable = 1'b1; start = 1'b1; op = mop; cmp = mcmp; rs = a; rt = b;
    tick();
    start = 1'b0;
    rs = 8'($urandom); rt = 8'($urandom);
    if (drop_en) enable = 1'b0;
    lat = 0; busy_cnt = 0; hold_bad = 0;
    while (!done_u && lat < 40) begin
      if (busy_u) busy_cnt++;
      if (out_u !== last_u || hi_u !== last_hi) hold_bad++;
      if (mid_start && lat == 2) begin
        start = 1'b1; enable = 1'b1; op = 2'b00; cmp = 1'b0; rs = 8'd1; rt = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk({name, " latency"}, lat, elat);
    chk({name, " busy_cycles"}, busy_cnt, elat);
    chk({name, " held_during_div"}, hold_bad, 0);
    chk({name, " alu_out"}, int'(out_u), int'(eu));
    chk({name, " alu_out_hi"}, int'(hi_u), int'(eh));
    chk({name, " div_by_zero"}, int'(dbz_u), int'(edbz));
    chk({name, " busy_at_done"}, int'(busy_u), 0);
    chk({name, " signed done"}, int'(done_s), 1);
    chk({name, " signed alu_out"}, int'(out_s), int'(es));
    last_u = eu; last_hi = eh;
    tick();
    enable = 1'b1;
    chk({name, " done_clear"}, int'(done_u), 0);
    chk({name, " dbz_clear"}, int'(dbz_u), 0);
    chk({name, " out_hold"}, int'(out_u), int'(last_u));
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] o, input logic c,
                              input logic [7:0] a, b, eu, es, eh, input logic d, input int l);
    vec_t v;
    v.name = n; v.op = o; v.cmp = c; v.a = a; v.b = b;
    v.eu = eu; v.es = es; v.eh = eh; v.dbz = d; v.lat = l;
    return v;
  endfunction

  initial begin
    logic [7:0] eu, es, eh;
    logic       edbz;
    int         elat;
    logic [1:0] rop;
    logic       rcmp;
    logic [7:0] ra, rb;

    tbl[0]  = mk("add_carry",   2'd0, 1'b0, 8'd200, 8'd100, 8'd44,  8'd44,  8'd1,  1'b0, 0);
    tbl[1]  = mk("add_wrap",    2'd0, 1'b0, 8'd255, 8'd1,   8'd0,   8'd0,   8'd1,  1'b0, 0);
    tbl[2]  = mk("sub_borrow",  2'd1, 1'b0, 8'd5,   8'd10,  8'd251, 8'd251, 8'd1,  1'b0, 0);
    tbl[3]  = mk("sub_plain",   2'd1, 1'b0, 8'd10,  8'd5,   8'd5,   8'd5,   8'd0,  1'b0, 0);
    tbl[4]  = mk("mul_max",     2'd2, 1'b0, 8'hFF,  8'hFF,  8'h01,  8'h01,  8'hFE, 1'b0, 0);
    tbl[5]  = mk("mul_256",     2'd2, 1'b0, 8'd16,  8'd16,  8'd0,   8'd0,   8'd1,  1'b0, 0);
    tbl[6]  = mk("cmp_fe_01",   2'd3, 1'b1, 8'hFE,  8'h01,  8'd4,   8'd1,   8'd0,  1'b0, 0);
    tbl[7]  = mk("cmp_01_fe",   2'd0, 1'b1, 8'h01,  8'hFE,  8'd1,   8'd4,   8'd0,  1'b0, 0);
    tbl[8]  = mk("cmp_eq",      2'd1, 1'b1, 8'd7,   8'd7,   8'd2,   8'd2,   8'd0,  1'b0, 0);
    tbl[9]  = mk("cmp_80_7f",   2'd3, 1'b1, 8'h80,  8'h7F,  8'd4,   8'd1,   8'd0,  1'b0, 0);
    tbl[10] = mk("div_zero",    2'd3, 1'b0, 8'd55,  8'd0,   8'hFF,  8'hFF,  8'd55, 1'b1, 0);
    tbl[11] = mk("div_100_7",   2'd3, 1'b0, 8'd100, 8'd7,   8'd14,  8'd14,  8'd2,  1'b0, 8);
    tbl[12] = mk("div_255_1",   2'd3, 1'b0, 8'd255, 8'd1,   8'd255, 8'd255, 8'd0,  1'b0, 8);
    tbl[13] = mk("div_3_200",   2'd3, 1'b0, 8'd3,   8'd200, 8'd0,   8'd0,   8'd3,  1'b0, 8);

    // Reset state
    #1;
    chk("reset alu_out", int'(out_u), 0);
    chk("reset alu_out_hi", int'(hi_u), 0);
    chk("reset busy", int'(busy_u), 0);
    chk("reset done", int'(done_u), 0);
    chk("reset dbz", int'(dbz_u), 0);
    tick(); tick();
    @(negedge clk); reset = 1'b1;
    tick();

    foreach (tbl[i])
      run_op(tbl[i].name, tbl[i].op, tbl[i].cmp, tbl[i].a, tbl[i].b,
             tbl[i].eu, tbl[i].es, tbl[i].eh, tbl[i].dbz, tbl[i].lat, 1'b0, 1'b0);

    // start pulsed in the middle of a divide must be ignored
    run_op("div_mid_start", 2'd3, 1'b0, 8'd100, 8'd7, 8'd14, 8'd14, 8'd2, 1'b0, 8, 1'b1, 1'b0);
    // enable dropping during a divide does not abort it
    run_op("div_en_drop", 2'd3, 1'b0, 8'd200, 8'd9, 8'd22, 8'd22, 8'd2, 1'b0, 8, 1'b0, 1'b1);

    // start with enable low is ignored
    enable = 1'b0; start = 1'b1; op = 2'd0; cmp = 1'b0; rs = 8'd9; rt = 8'd9;
    tick();
    start = 1'b0; enable = 1'b1;
    chk("disabled no_done", int'(done_u), 0);
    chk("disabled out_hold", int'(out_u), int'(last_u));

    // back-to-back issue: done on consecutive cycles
    start = 1'b1; op = 2'd0; rs = 8'd1; rt = 8'd2;
    tick();
    chk("b2b first done", int'(done_u), 1);
    chk("b2b first out", int'(out_u), 3);
    op = 2'd2; rs = 8'd3; rt = 8'd4;
    tick();
    start = 1'b0;
    chk("b2b second done", int'(done_u), 1);
    chk("b2b second out", int'(out_u), 12);
    chk("b2b second hi", int'(hi_u), 0);
    last_u = 8'd12; last_hi = 8'd0;
    tick();
    chk("b2b done_clear", int'(done_u), 0);

    // reset asserted three cycles into a divide
    start = 1'b1; op = 2'd3; cmp = 1'b0; rs = 8'd100; rt = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("middiv busy", int'(busy_u), 1);
    #2 reset = 1'b0;
    #1;
    chk("middiv reset out", int'(out_u), 0);
    chk("middiv reset hi", int'(hi_u), 0);
    chk("middiv reset busy", int'(busy_u), 0);
    chk("middiv reset done", int'(done_u), 0);
    @(negedge clk); reset = 1'b1;
    last_u = 8'd0; last_hi = 8'd0;
    tick();
    run_op("post_reset_add", 2'd0, 1'b0, 8'd200, 8'd100, 8'd44, 8'd44, 8'd1, 1'b0, 0, 1'b0, 1'b0);

    // randomized operations against the model
    for (int k = 0; k < 150; k++) begin
      rop  = 2'($urandom_range(0, 3));
      rcmp = ($urandom_range(0, 4) == 0);
      ra   = 8'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(rop, rcmp, ra, rb, eu, es, eh, edbz, elat);
      run_op($sformatf("rand%0d", k), rop, rcmp, ra, rb, eu, es, eh, edbz, elat,
             1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
